// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes and arbiter FSM encoding for the ALU sharing block.
package alu_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned SELW = 3;

  localparam logic [SELW-1:0] OP_ADD = SELW'(0);
  localparam logic [SELW-1:0] OP_SUB = SELW'(1);
  localparam logic [SELW-1:0] OP_NOT = SELW'(2);
  localparam logic [SELW-1:0] OP_SHL = SELW'(3);
  localparam logic [SELW-1:0] OP_SHR = SELW'(4);
  localparam logic [SELW-1:0] OP_AND = SELW'(5);
  localparam logic [SELW-1:0] OP_OR  = SELW'(6);
  localparam logic [SELW-1:0] OP_SLT = SELW'(7);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // One ALU operation as presented by a requester.
  typedef struct packed {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [SELW-1:0] sel;
  } alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_grant
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NREQ);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_grant) grant = NREQ'(1) << grant_idx;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: accept, execute one cycle,
// then hold the captured result until the granted requester takes it.
module alu_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = alu_pkg::DW,
  parameter int unsigned SELW = alu_pkg::SELW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*SELW-1:0] req_sel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_zero,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [SELW-1:0]      alu_sel,
  input  logic [DW-1:0]        alu_result,
  input  logic                 alu_zero,
  output logic                 busy
);

  import alu_pkg::*;

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q;
  logic [DW-1:0]   op_a_q, op_b_q, res_q;
  logic [SELW-1:0] op_sel_q;
  logic            zero_q;
  logic            accept;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Next state, pointer advance and handshake decode.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted even though IDLE is the reset state.
        if (rst_n && arb_any) req_ready = arb_grant;
        accept = |(req_valid & req_ready);
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = NREQ'(1) << grant_q;
        if (rsp_ready[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        grant_q  <= arb_idx;
        op_a_q   <= req_a[32'(arb_idx)*DW +: DW];
        op_b_q   <= req_b[32'(arb_idx)*DW +: DW];
        op_sel_q <= req_sel[32'(arb_idx)*SELW +: SELW];
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 16-bit ALU attached.
module tb_alu_arbiter;

  import alu_pkg::*;

  localparam int unsigned NREQ = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ*SELW-1:0] req_sel;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [DW-1:0]        rsp_result;
  logic                 rsp_zero;
  logic [DW-1:0]        alu_a, alu_b, alu_result;
  logic [SELW-1:0]      alu_sel;
  logic                 alu_zero;
  logic                 busy;

  int tests_run = 0;
  int tests_failed = 0;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .SELW(SELW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  // The shared ALU the arbiter fronts.
  always_comb begin
    case (alu_sel)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_NOT:  alu_result = ~alu_a;
      OP_SHL:  alu_result = alu_a << alu_b[3:0];
      OP_SHR:  alu_result = alu_a >> alu_b[3:0];
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      default: alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string   name;
    int      idx;
    alu_op_t op;
    logic [DW-1:0] exp_result;
    logic    exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SELW-1:0] sel);
    req_a[idx*DW +: DW]       = a;
    req_b[idx*DW +: DW]       = b;
    req_sel[idx*SELW +: SELW] = sel;
  endtask

  // One complete transaction from a single requester, checked cycle by cycle.
  task automatic run_op(input vec_t v);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << v.idx;
    set_req(v.idx, v.op.a, v.op.b, v.op.sel);
    @(negedge clk); req_valid = oh; rsp_ready = '0;
    #1 chk({v.name, ".req_ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk); req_valid = '0;
    #1 chk({v.name, ".exec_busy"}, 32'(busy), 32'd1);
    chk({v.name, ".exec_ready"}, 32'(req_ready), 32'd0);
    chk({v.name, ".alu_a"}, 32'(alu_a), 32'(v.op.a));
    chk({v.name, ".alu_b"}, 32'(alu_b), 32'(v.op.b));
    chk({v.name, ".alu_sel"}, 32'(alu_sel), 32'(v.op.sel));
    @(negedge clk); rsp_ready = '1;
    #1 chk({v.name, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({v.name, ".rsp_result"}, 32'(rsp_result), 32'(v.exp_result));
    chk({v.name, ".rsp_zero"}, 32'(rsp_zero), 32'(v.exp_zero));
    @(negedge clk); rsp_ready = '0;
    #1 chk({v.name, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({v.name, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, ".alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, ".alu_sel"}, 32'(alu_sel), 32'd0);
    chk({tag, ".rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, ".rsp_zero"}, 32'(rsp_zero), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"add",      0, '{16'h0003, 16'h0005, OP_ADD}, 16'h0008, 1'b0};
    vecs[1] = '{"sub_zero", 1, '{16'h1234, 16'h1234, OP_SUB}, 16'h0000, 1'b1};
    vecs[2] = '{"shl",      0, '{16'h0001, 16'h0004, OP_SHL}, 16'h0010, 1'b0};
    vecs[3] = '{"slt_uns",  1, '{16'hFFFF, 16'h0001, OP_SLT}, 16'h0000, 1'b1};
    vecs[4] = '{"and",      0, '{16'hF0F0, 16'h0FF0, OP_AND}, 16'h00F0, 1'b0};
    vecs[5] = '{"or",       1, '{16'hF000, 16'h000F, OP_OR},  16'hF00F, 1'b0};
    vecs[6] = '{"not",      0, '{16'h00FF, 16'h0000, OP_NOT}, 16'hFF00, 1'b0};
    vecs[7] = '{"shr",      1, '{16'h8000, 16'h0003, OP_SHR}, 16'h1000, 1'b0};
    vecs[8] = '{"add_ovf",  0, '{16'hFFFF, 16'h0001, OP_ADD}, 16'h0000, 1'b1};
    vecs[9] = '{"sub_wrap", 1, '{16'h0000, 16'h0001, OP_SUB}, 16'hFFFF, 1'b0};

    rst_n = 1'b0; req_valid = 2'b01; rsp_ready = '0;
    req_a = '0; req_b = '0; req_sel = '0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req_valid = '0;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Round robin from a fresh reset with both requesters always valid.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_req(0, 16'h0001, 16'h0001, OP_ADD);
    set_req(1, 16'h0002, 16'h0002, OP_ADD);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int op = 0; op < 6; op++) begin
      #1 chk("rr.grant", 32'(req_ready), 32'(NREQ'(1) << (op % 2)));
      chk("rr.onehot", 32'($countones(req_ready) <= 1), 32'd1);
      @(negedge clk);
      #1 chk("rr.exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1 chk("rr.rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << (op % 2)));
      chk("rr.rsp_result", 32'(rsp_result), (op % 2 == 0) ? 32'h2 : 32'h4);
      chk("rr.resp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = '0;

    // Backpressure on requester 0 while requester 1 waits.
    set_req(0, 16'h0010, 16'h0020, OP_ADD);
    set_req(1, 16'h0005, 16'h0007, OP_SUB);
    @(negedge clk); req_valid = 2'b11;
    #1 chk("bp.grant0", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid = 2'b10;
    #1 chk("bp.exec_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); rsp_ready = 2'b10;
      #1 chk("bp.hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp.hold_result", 32'(rsp_result), 32'h0030);
      chk("bp.hold_zero", 32'(rsp_zero), 32'd0);
      chk("bp.hold_ready", 32'(req_ready), 32'd0);
      chk("bp.hold_busy", 32'(busy), 32'd1);
    end
    @(negedge clk); rsp_ready = 2'b01;
    #1 chk("bp.release_valid", 32'(rsp_valid), 32'h1);
    @(negedge clk); rsp_ready = 2'b00;
    #1 chk("bp.grant1", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0;
    #1 chk("bp.alu_a1", 32'(alu_a), 32'h0005);
    chk("bp.alu_sel1", 32'(alu_sel), 32'(OP_SUB));
    @(negedge clk); rsp_ready = 2'b10;
    #1 chk("bp.rsp1_valid", 32'(rsp_valid), 32'h2);
    chk("bp.rsp1_result", 32'(rsp_result), 32'hFFFE);
    @(negedge clk); rsp_ready = '0;
    #1 chk("bp.idle", 32'(busy), 32'd0);
    chk("bp.result_held", 32'(rsp_result), 32'hFFFE);

    // Reset during EXEC drops the operation.
    set_req(0, 16'h00FF, 16'h0003, OP_NOT);
    set_req(1, 16'h0100, 16'h0001, OP_ADD);
    @(negedge clk); req_valid = 2'b01;
    #1 chk("rst.grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1 chk("rst.exec_a", 32'(alu_a), 32'h00FF);
    chk("rst.exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_all_zero("rst.mid");
    @(negedge clk);
    #1 chk("rst.no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b10;
    #1 chk("rst.grant1", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0;
    #1 chk("rst.no_rsp0", 32'(rsp_valid), 32'd0);
    chk("rst.alu_a1", 32'(alu_a), 32'h0100);
    @(negedge clk); rsp_ready = 2'b11;
    #1 chk("rst.rsp1_valid", 32'(rsp_valid), 32'h2);
    chk("rst.rsp1_result", 32'(rsp_result), 32'h0101);
    @(negedge clk); rsp_ready = '0;
    #1 chk("rst.final_valid", 32'(rsp_valid), 32'd0);
    chk("rst.final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
